// File: rtl/vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// vram_arbiter_if
// CPU-side bus between the Z80 bus decoder and the VRAM arbiter.
//   cpu_req   : access request, level, held until cpu_ack
//   cpu_we    : 1 = write, 0 = read (stable while cpu_req is high)
//   cpu_addr  : access address (stable while cpu_req is high)
//   cpu_wdata : write data (stable while cpu_req is high)
//   cpu_rdata : read data, valid while cpu_ack is high
//   cpu_ack   : one-cycle completion pulse
//   cpu_wait  : cpu_req & ~cpu_ack, drives the Z80 WAIT input
// master = CPU / bus decoder side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_wait;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_wait
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_wait
    );
endinterface

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous video RAM between video fetch, the Z80
// CPU and a built-in screen-fill engine. Fixed priority video > CPU > fill;
// one RAM slot per clock, the RAM address/control is registered.
//
// Ports:
//   CLOCK, RESET           : pixel clock, asynchronous active-high reset
//   vid_req/vid_addr       : video fetch request (every edge) and address
//   vid_data/vid_valid     : fetched byte, one-cycle valid pulse
//   cpu (interface slave)  : CPU request/ack bus with WAIT output
//   fill_start/fill_value  : start pulse and fill byte for the fill engine
//   fill_busy/fill_done    : fill in progress / one-cycle completion pulse
//   mem_addr/mem_we/mem_wdata : registered RAM slot
//   mem_rdata              : RAM read data, one cycle after the slot
// ---------------------------------------------------------------------------
module vram_arbiter #(
    parameter int            AW        = 16,
    parameter int            DW        = 8,
    parameter logic [AW-1:0] FILL_BASE = 16'h4000,
    parameter logic [AW-1:0] FILL_END  = 16'h9FFF
) (
    input  logic          CLOCK,
    input  logic          RESET,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,

    vram_arbiter_if.slave cpu,

    input  logic          fill_start,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          fill_done,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU_RD,
        TAG_CPU_WR,
        TAG_FILL
    } tag_t;

    typedef enum logic {
        F_IDLE,
        F_RUN
    } fstate_t;

    fstate_t       state;
    fstate_t       state_nxt;
    tag_t          tag_p1;
    tag_t          tag_p2;
    logic [AW-1:0] fill_ptr;
    logic [DW-1:0] fill_val;

    logic          cpu_busy;
    logic          cpu_elig;
    logic          grant_cpu;
    logic          grant_fill;
    logic          fill_last;

    tag_t          slot_tag;
    logic [AW-1:0] slot_addr;
    logic          slot_we;
    logic [DW-1:0] slot_wdata;

    // A CPU transaction counts as outstanding from its grant until the end of
    // its ack cycle, so a cpu_req still high during the ack is not re-granted.
    always_comb begin
        cpu_busy   = (tag_p1 == TAG_CPU_RD) || (tag_p1 == TAG_CPU_WR) ||
                     (tag_p2 == TAG_CPU_RD) || cpu.cpu_ack;
        cpu_elig   = cpu.cpu_req & ~cpu_busy;
        grant_cpu  = ~vid_req & cpu_elig;
        grant_fill = ~vid_req & ~cpu_elig & (state == F_RUN);
        fill_last  = grant_fill & (fill_ptr == FILL_END);
    end

    assign cpu.cpu_wait = cpu.cpu_req & ~cpu.cpu_ack;

    // Slot owner selection; an idle slot keeps the last address.
    always_comb begin
        slot_tag   = TAG_NONE;
        slot_addr  = mem_addr;
        slot_we    = 1'b0;
        slot_wdata = mem_wdata;
        if (vid_req) begin
            slot_tag  = TAG_VID;
            slot_addr = vid_addr;
        end else if (grant_cpu) begin
            slot_tag   = cpu.cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
            slot_addr  = cpu.cpu_addr;
            slot_we    = cpu.cpu_we;
            slot_wdata = cpu.cpu_wdata;
        end else if (grant_fill) begin
            slot_tag   = TAG_FILL;
            slot_addr  = fill_ptr;
            slot_we    = 1'b1;
            slot_wdata = fill_val;
        end
    end

    // Stage p1: slot registered towards the RAM, owner tag travels with it.
    // Stage p2: RAM is reading; tag follows so the data can be routed.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            tag_p1    <= TAG_NONE;
            tag_p2    <= TAG_NONE;
        end else begin
            mem_addr  <= slot_addr;
            mem_we    <= slot_we;
            mem_wdata <= slot_wdata;
            tag_p1    <= slot_tag;
            tag_p2    <= tag_p1;
        end
    end

    // Return stage: read data captured two edges after the slot; a CPU write
    // is acknowledged one edge after its slot.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            vid_data      <= '0;
            vid_valid     <= 1'b0;
            cpu.cpu_rdata <= '0;
            cpu.cpu_ack   <= 1'b0;
        end else begin
            vid_valid   <= (tag_p2 == TAG_VID);
            cpu.cpu_ack <= (tag_p2 == TAG_CPU_RD) || (tag_p1 == TAG_CPU_WR);
            if (tag_p2 == TAG_VID) begin
                vid_data <= mem_rdata;
            end
            if (tag_p2 == TAG_CPU_RD) begin
                cpu.cpu_rdata <= mem_rdata;
            end
        end
    end

    // Fill FSM: state register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= F_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Fill FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE: if (fill_start) state_nxt = F_RUN;
            F_RUN:  if (fill_last)  state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    // Fill FSM: outputs
    always_comb begin
        fill_busy = (state == F_RUN);
    end

    // Fill pointer/value; fill_done rises on the edge that writes FILL_END.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            fill_ptr  <= '0;
            fill_val  <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= (state == F_RUN) && fill_last;
            if ((state == F_IDLE) && fill_start) begin
                fill_val <= fill_value;
                fill_ptr <= FILL_BASE;
            end else if (grant_fill) begin
                fill_ptr <= fill_ptr + AW'(1);
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between three requesters: video fetch, Z80 CPU and a built-in screen-fill engine.
- Priority is fixed: video > CPU > fill.
- Video fetch is never stalled. The CPU is held off with a WAIT-style signal. The fill engine uses only idle slots.
- Sits between the CPU bus decoder, the video adapter's vaddr/vdata path and the RAM block.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- FILL_BASE, 16'h4000, first fill address (video memory start).
- FILL_END, 16'h9FFF, last fill address, inclusive.

Ports:
- CLOCK  in  1  system clock (pixel clock domain)
- RESET  in  1  asynchronous, active-high reset
- vid_req  in  1  video fetch request, sampled every edge
- vid_addr  in  AW  video fetch address
- vid_data  out  DW  fetched video byte
- vid_valid  out  1  one-cycle pulse: vid_data updated
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  AW  CPU address; stable while cpu_req is high
- cpu_wdata  in  DW  CPU write data; stable while cpu_req is high
- cpu_rdata  out  DW  CPU read data, valid while cpu_ack is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  cpu_req & ~cpu_ack (combinational), drives Z80 WAIT
- fill_start  in  1  pulse: begin fill
- fill_value  in  DW  fill byte, sampled on fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after the last fill write
- mem_addr  out  AW  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_rdata  in  DW  RAM read data, valid one cycle after the address is registered

Behaviour:
- Reset values:
  - mem_addr, mem_wdata, vid_data and cpu_rdata are 0.
  - mem_we, vid_valid, cpu_ack, fill_busy and fill_done are 0.
  - The fill FSM is F_IDLE and the in-flight pipeline tags are cleared.
- One slot per clock. At edge k the arbiter picks the owner and registers mem_addr/mem_we/mem_wdata:
  - vid_req=1: video read.
  - else, CPU eligible: CPU access.
  - else, fill_busy=1: fill write.
  - else: mem_we=0 and mem_addr holds its last value.
- mem_we is 1 only for CPU writes and fill writes.
- Read pipeline: the owner tag is registered with the slot. mem_rdata is valid in cycle k+1 and captured at edge k+2.
  - Video read: vid_data<=mem_rdata and vid_valid=1 for one cycle.
  - CPU read: cpu_rdata<=mem_rdata and cpu_ack=1 for one cycle.
  - Result: request at edge k gives data at edge k+2.
- CPU write: cpu_ack pulses at edge k+1, the cycle after the slot is registered.
- CPU eligibility: cpu_req=1 and no CPU transaction in flight (issued but not yet acked). A single outstanding transaction is the rule. cpu_req still high during the ack cycle must not be re-granted.
- CPU starvation: none, because the video source requests on alternate cycles. The bench must still tolerate an arbitrary vid_req pattern.
- Fill FSM states are F_IDLE and F_RUN.
  - F_IDLE + fill_start: latch fill_value, ptr<=FILL_BASE, go to F_RUN, fill_busy=1.
  - F_RUN: each granted fill slot writes fill_value to ptr, then ptr<=ptr+1.
  - The slot writing FILL_END returns the FSM to F_IDLE: fill_busy drops and fill_done pulses at the same edge.
  - fill_start while in F_RUN is ignored.
- Simultaneous CPU write and fill to the same address: the CPU write happens first and the fill overwrites it later. This is accepted behaviour and is not tracked.
- RESET mid-operation:
  - In-flight reads are discarded; no vid_valid or cpu_ack is issued for them.
  - The fill aborts without a fill_done pulse.
  - A CPU holding cpu_req is granted as a fresh request after RESET deasserts.
- Address arithmetic is AW bits. ptr does not wrap past FILL_END because the FSM exits there.

Test Plan:
1. Video only: vid_req=1 on alternate edges, addr 4000h/4001h, RAM preloaded with A5h/5Ah → vid_valid 2 cycles after each request, vid_data A5h then 5Ah, mem_we always 0.
2. CPU write then read at 5123h with data 3Ch during video-idle cycles:
   - Write: cpu_ack 1 cycle after the grant.
   - Read: cpu_ack 2 cycles after the grant with cpu_rdata=3Ch.
   - cpu_wait high from request to ack, exactly one ack per request.
3. Contention: vid_req and cpu_req both high at the same edge → video owns that slot; CPU granted at the next edge with vid_req=0; vid_valid timing unchanged.
4. Fill: fill_start with fill_value=07h, no other traffic:
   - fill_busy high for exactly 24576 cycles (4000h–9FFFh).
   - fill_done pulses once; RAM[4000h..9FFFh]=07h; RAM[3FFFh] and RAM[A000h] untouched.
5. Fill with alternating video and a CPU write at 8000h during the fill → video never delayed; CPU acked; fill completes with all bytes written and total slots consistent.
6. RESET asserted during a pending CPU read and a running fill → all outputs return to reset values immediately, no stray ack or done pulses; the held cpu_req completes normally after release.
